uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//
// Polls an upstream uart block over a simple master bus and buffers the
// received bytes in a DEPTH-entry FIFO. The CPU reads the FIFO through a
// small slave register file.
//
// Parameters
//   DEPTH      FIFO entries (power of two, 2..128)
//   UART_BASE  bus base address of the upstream uart block
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low reset
//   m_address_out       master address to uart
//   m_sel_out           master select
//   m_read_out          master read strobe
//   m_read_value_in     uart read data
//   m_write_mask_out    always 4'b0 (the poller only reads)
//   m_write_value_out   always 32'b0
//   m_ready_in          uart transfer complete
//   address_in          CPU slave address, register select = address_in[3:2]
//   sel_in              CPU slave select
//   read_in             CPU read strobe
//   read_value_out      CPU read data (0 when not selected)
//   write_mask_in       CPU byte write enables
//   write_value_in      CPU write data
//   ready_out           slave ready, mirrors sel_in
//   irq_out             level interrupt
//
// Slave registers (address_in[3:2])
//   0 STATUS  RO  {16'b0, count[7:0], 5'b0, ovf, full, nonempty}
//   1 DATA    RO  {{24{empty}}, empty ? 8'b0 : head}; reading pops
//   2 THRESH  RW  bits[7:0]
//   3 CTRL        bit0 en (RW), bit1 ovf clear (W1C), bit2 flush (W1)
//
// Poll FSM
//   state   | meaning
//   IDLE    | master bus quiet; start a poll when en=1
//   RD_STAT | reading uart status at UART_BASE+4
//   RD_DATA | one idle cycle, then reading uart data at UART_BASE+8

module uart_rx_fifo #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] UART_BASE = 32'h0
) (
   input  logic        clk,
   input  logic        reset,

   output logic [31:0] m_address_out,
   output logic        m_sel_out,
   output logic        m_read_out,
   input  logic [31:0] m_read_value_in,
   output logic [3:0]  m_write_mask_out,
   output logic [31:0] m_write_value_out,
   input  logic        m_ready_in,

   input  logic [31:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [31:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic        ready_out,
   output logic        irq_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_THRESH = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_STAT = 2'd1,
      RD_DATA = 2'd2
   } state_t;

   state_t          state;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic            ovf;
   logic            ovf_nxt;
   logic            en;
   logic [7:0]      thresh;

   logic [1:0]      reg_sel;
   logic            cpu_wr;
   logic            do_flush;
   logic            ovf_clr;
   logic            empty;
   logic            full;
   logic            pop_req;
   logic            push_req;
   logic            do_pop;
   logic            do_push;
   logic            ovf_set;
   logic            irq_nxt;
   logic [7:0]      count8;
   logic [7:0]      head;

   assign m_write_mask_out  = 4'b0;
   assign m_write_value_out = 32'b0;
   assign ready_out         = sel_in;

   // ------------------------------------------------------------------
   // Slave decode
   // ------------------------------------------------------------------
   assign reg_sel  = address_in[3:2];
   // Every writable field lives in byte 0, so only mask bit 0 matters.
   assign cpu_wr   = sel_in && !read_in && write_mask_in[0];
   assign do_flush = cpu_wr && (reg_sel == REG_CTRL) && write_value_in[2];
   assign ovf_clr  = cpu_wr && (reg_sel == REG_CTRL) && write_value_in[1];

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign count8   = 8'(count);
   assign head     = mem[rd_ptr];

   assign pop_req  = sel_in && read_in && (reg_sel == REG_DATA) && !empty;
   // Handshake completes on the data read; m_sel_out is low in the
   // setup cycle of RD_DATA so a stale ready there is ignored.
   assign push_req = (state == RD_DATA) && m_sel_out && m_ready_in;

   // Flush wins over both sides: the pop is ignored and the byte dropped
   // without counting as an overflow.
   assign do_pop   = pop_req && !do_flush;
   assign do_push  = push_req && !do_flush && (!full || do_pop);
   assign ovf_set  = push_req && !do_flush && full && !do_pop;

   always_comb begin
      count_nxt = count;
      if (do_flush) begin
         count_nxt = '0;
      end else if (do_push && !do_pop) begin
         count_nxt = count + CW'(1);
      end else if (!do_push && do_pop) begin
         count_nxt = count - CW'(1);
      end
   end

   // A new overflow in the same cycle as a clear must not be lost.
   always_comb begin
      ovf_nxt = ovf;
      if (ovf_set) begin
         ovf_nxt = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt = 1'b0;
      end
   end

   // Interrupt is computed from next-state values so it lines up with the
   // count that becomes visible after the same edge.
   assign irq_nxt = ((count_nxt != '0) && (8'(count_nxt) >= thresh)) || ovf_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         en      <= 1'b0;
         thresh  <= 8'd1;
         irq_out <= 1'b0;
      end else begin
         if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
         end
         count   <= count_nxt;
         ovf     <= ovf_nxt;
         irq_out <= irq_nxt;
         if (cpu_wr && (reg_sel == REG_CTRL)) begin
            en <= write_value_in[0];
         end
         if (cpu_wr && (reg_sel == REG_THRESH)) begin
            thresh <= write_value_in[7:0];
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= m_read_value_in[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Slave read mux
   // ------------------------------------------------------------------
   always_comb begin
      read_value_out = 32'b0;
      if (sel_in) begin
         case (reg_sel)
            REG_STATUS: read_value_out = {16'b0, count8, 5'b0, ovf, full, !empty};
            REG_DATA:   read_value_out = {{24{empty}}, (empty ? 8'b0 : head)};
            REG_THRESH: read_value_out = {24'b0, thresh};
            REG_CTRL:   read_value_out = {31'b0, en};
            default:    read_value_out = 32'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Poll FSM
   // ------------------------------------------------------------------
   // Master outputs drop to zero on every completed transfer, so the bus
   // always sees at least one deselected cycle between the status read
   // and the data read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         m_sel_out     <= 1'b0;
         m_read_out    <= 1'b0;
         m_address_out <= 32'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state         <= RD_STAT;
                  m_sel_out     <= 1'b1;
                  m_read_out    <= 1'b1;
                  m_address_out <= UART_BASE + 32'd4;
               end
            end
            RD_STAT: begin
               if (m_ready_in) begin
                  m_sel_out     <= 1'b0;
                  m_read_out    <= 1'b0;
                  m_address_out <= 32'b0;
                  state         <= m_read_value_in[1] ? RD_DATA : IDLE;
               end
            end
            RD_DATA: begin
               if (!m_sel_out) begin
                  m_sel_out     <= 1'b1;
                  m_read_out    <= 1'b1;
                  m_address_out <= UART_BASE + 32'd8;
               end else if (m_ready_in) begin
                  m_sel_out     <= 1'b0;
                  m_read_out    <= 1'b0;
                  m_address_out <= 32'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               m_sel_out     <= 1'b0;
               m_read_out    <= 1'b0;
               m_address_out <= 32'b0;
            end
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1],
                          write_value_in[31:8], m_read_value_in[31:8]};

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk;
   logic        reset;
   logic [31:0] m_address_out;
   logic        m_sel_out;
   logic        m_read_out;
   logic [31:0] m_read_value_in;
   logic [3:0]  m_write_mask_out;
   logic [31:0] m_write_value_out;
   logic        m_ready_in;
   logic [31:0] address_in;
   logic        sel_in;
   logic        read_in;
   logic [31:0] read_value_out;
   logic [3:0]  write_mask_in;
   logic [31:0] write_value_in;
   logic        ready_out;
   logic        irq_out;

   int checks = 0;
   int passed = 0;

   uart_rx_fifo #(.DEPTH(16), .UART_BASE(BASE)) dut (
      .clk               (clk),
      .reset             (reset),
      .m_address_out     (m_address_out),
      .m_sel_out         (m_sel_out),
      .m_read_out        (m_read_out),
      .m_read_value_in   (m_read_value_in),
      .m_write_mask_out  (m_write_mask_out),
      .m_write_value_out (m_write_value_out),
      .m_ready_in        (m_ready_in),
      .address_in        (address_in),
      .sel_in            (sel_in),
      .read_in           (read_in),
      .read_value_out    (read_value_out),
      .write_mask_in     (write_mask_in),
      .write_value_in    (write_value_in),
      .ready_out         (ready_out),
      .irq_out           (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All tasks start and end at a falling edge.
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else passed++;
   endtask

   task automatic cpu_read(input logic [1:0] r, output logic [31:0] d);
      sel_in = 1'b1; read_in = 1'b1; write_mask_in = 4'h0;
      address_in = {28'h0, r, 2'b00};
      #1 d = read_value_out;
      @(posedge clk); @(negedge clk);
      sel_in = 1'b0; read_in = 1'b0; address_in = 32'h0;
   endtask

   task automatic cpu_write(input logic [1:0] r, input logic [31:0] v);
      sel_in = 1'b1; read_in = 1'b0; write_mask_in = 4'hF;
      address_in = {28'h0, r, 2'b00}; write_value_in = v;
      @(posedge clk); @(negedge clk);
      sel_in = 1'b0; write_mask_in = 4'h0; address_in = 32'h0; write_value_in = 32'h0;
   endtask

   // Uart responder for one master transfer. op: 0 none, 1 CPU DATA pop,
   // 2 CPU flush write, both on the same edge as the uart ready.
   task automatic serve(input logic [31:0] val, input logic [31:0] exp_addr, input int op);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_sel_out) begin seen = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         $display("FAIL serve_timeout: got m_sel_out=0 expected 1 within 40 cycles");
         return;
      end
      passed++;
      chk("m_address", m_address_out, exp_addr);
      m_read_value_in = val; m_ready_in = 1'b1;
      if (op == 1) begin
         sel_in = 1'b1; read_in = 1'b1; address_in = 32'h4;
      end else if (op == 2) begin
         sel_in = 1'b1; read_in = 1'b0; address_in = 32'hC;
         write_mask_in = 4'hF; write_value_in = 32'h5;
      end
      @(posedge clk); @(negedge clk);
      m_ready_in = 1'b0; m_read_value_in = 32'h0;
      sel_in = 1'b0; read_in = 1'b0; address_in = 32'h0;
      write_mask_in = 4'h0; write_value_in = 32'h0;
      chk("sel_gap", {31'h0, m_sel_out}, 32'h0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      serve(32'h2, BASE + 32'd4, 0);
      serve({24'h0, b}, BASE + 32'd8, 0);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      chk("rst_m_sel", {31'h0, m_sel_out}, 32'h0);
      chk("rst_m_addr", m_address_out, 32'h0);
      chk("rst_irq", {31'h0, irq_out}, 32'h0);
      chk("rst_wmask", {28'h0, m_write_mask_out}, 32'h0);
      sel_in = 1'b1; #1;
      chk("ready_out", {31'h0, ready_out}, 32'h1);
      sel_in = 1'b0; #1;
      chk("rd_unsel", read_value_out, 32'h0);
      @(negedge clk);
      cpu_read(2'd0, d); chk("rst_status", d, 32'h0);
      cpu_read(2'd2, d); chk("rst_thresh", d, 32'h1);
   endtask

   task automatic test_empty_read();
      logic [31:0] d;
      cpu_read(2'd1, d); chk("empty_data", d, 32'hFFFF_FF00);
      cpu_read(2'd0, d); chk("empty_status", d, 32'h0);
   endtask

   task automatic test_single();
      logic [31:0] d;
      cpu_write(2'd3, 32'h1);
      push_byte(8'h41);
      cpu_read(2'd0, d); chk("single_status", d, 32'h0000_0101);
      chk("single_irq", {31'h0, irq_out}, 32'h1);
      cpu_read(2'd1, d); chk("single_data", d, 32'h0000_0041);
      chk("single_irq_clr", {31'h0, irq_out}, 32'h0);
      cpu_read(2'd0, d); chk("single_status0", d, 32'h0);
      // Disable while a status read is outstanding: it must still finish.
      cpu_write(2'd3, 32'h0);
      chk("inflight_sel", {31'h0, m_sel_out}, 32'h1);
      serve(32'h0, BASE + 32'd4, 0);
      repeat (3) @(negedge clk);
      chk("disabled_idle", {31'h0, m_sel_out}, 32'h0);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      cpu_write(2'd3, 32'h1);
      for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
      cpu_read(2'd0, d); chk("ovf_status", d, 32'h0000_1007);
      chk("ovf_irq", {31'h0, irq_out}, 32'h1);
      for (int i = 0; i < 16; i++) begin
         cpu_read(2'd1, d); chk("ovf_data", d, 32'h10 + 32'(i));
      end
      cpu_read(2'd1, d); chk("ovf_17th_lost", d, 32'hFFFF_FF00);
      cpu_read(2'd0, d); chk("ovf_sticky", d, 32'h0000_0004);
      cpu_write(2'd3, 32'h3);
      cpu_read(2'd0, d); chk("ovf_cleared", d, 32'h0);
      chk("ovf_irq_clr", {31'h0, irq_out}, 32'h0);
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
      cpu_read(2'd0, d); chk("full_status", d, 32'h0000_1003);
      serve(32'h2, BASE + 32'd4, 0);
      serve(32'h99, BASE + 32'd8, 1);
      cpu_read(2'd0, d); chk("fullpp_status", d, 32'h0000_1003);
      for (int i = 1; i < 16; i++) begin
         cpu_read(2'd1, d); chk("fullpp_data", d, 32'h20 + 32'(i));
      end
      cpu_read(2'd1, d); chk("fullpp_tail", d, 32'h99);
   endtask

   task automatic test_flush();
      logic [31:0] d;
      for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
      serve(32'h2, BASE + 32'd4, 0);
      serve(32'h77, BASE + 32'd8, 2);
      cpu_read(2'd0, d); chk("flush_status", d, 32'h0);
      cpu_read(2'd1, d); chk("flush_data", d, 32'hFFFF_FF00);
      cpu_read(2'd3, d); chk("flush_ctrl", d, 32'h1);
   endtask

   task automatic test_thresh();
      logic [31:0] d;
      cpu_write(2'd2, 32'h4);
      cpu_read(2'd2, d); chk("thresh_rb", d, 32'h4);
      for (int i = 0; i < 3; i++) push_byte(8'h51 + 8'(i));
      chk("thresh_irq3", {31'h0, irq_out}, 32'h0);
      cpu_read(2'd0, d); chk("thresh_status3", d, 32'h0000_0301);
      push_byte(8'h54);
      chk("thresh_irq4", {31'h0, irq_out}, 32'h1);
      cpu_read(2'd1, d); chk("thresh_pop", d, 32'h51);
      chk("thresh_irq_pop", {31'h0, irq_out}, 32'h0);
      for (int i = 0; i < 3; i++) cpu_read(2'd1, d);
      chk("thresh_last", d, 32'h54);
      cpu_write(2'd2, 32'h0);
      push_byte(8'h60);
      chk("thresh0_irq", {31'h0, irq_out}, 32'h1);
      cpu_read(2'd1, d); chk("thresh0_data", d, 32'h60);
      chk("thresh0_irq_clr", {31'h0, irq_out}, 32'h0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit stayed;
      push_byte(8'h70);
      serve(32'h2, BASE + 32'd4, 0);
      @(negedge clk);
      chk("mid_sel", {31'h0, m_sel_out}, 32'h1);
      chk("mid_addr", m_address_out, BASE + 32'd8);
      reset = 1'b0; #1;
      chk("mid_rst_sel", {31'h0, m_sel_out}, 32'h0);
      chk("mid_rst_read", {31'h0, m_read_out}, 32'h0);
      sel_in = 1'b1; read_in = 1'b1; address_in = 32'h0; #1;
      chk("mid_rst_count", read_value_out, 32'h0);
      sel_in = 1'b0; read_in = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      stayed = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (m_sel_out) stayed = 0;
      end
      chk("mid_stay_idle", {31'h0, stayed}, 32'h1);
      cpu_read(2'd2, d); chk("mid_thresh", d, 32'h1);
      cpu_read(2'd1, d); chk("mid_empty", d, 32'hFFFF_FF00);
   endtask

   initial begin
      reset = 1'b0;
      m_read_value_in = 32'h0; m_ready_in = 1'b0;
      address_in = 32'h0; sel_in = 1'b0; read_in = 1'b0;
      write_mask_in = 4'h0; write_value_in = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_empty_read();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_thresh();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
